// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, requester ids
// and the default memory address width.
package dm_arb_pkg;

    localparam int MEM_AW_DEF = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

endpackage

// File: rtl/dm_arbiter_if.sv
// Requester-side and memory-side bundle of the data-memory arbiter.
// slave = arbiter view, master = requesters + memory view.
interface dm_arbiter_if
    import dm_arb_pkg::*;
#(
    parameter int MEM_AW = MEM_AW_DEF
);
    logic [1:0]        req_i;
    logic [1:0]        we_i;
    logic [1:0][31:0]  addr_i;
    logic [1:0][31:0]  wdata_i;
    logic [1:0][3:0]   byteen_i;
    logic [1:0]        gnt_o;
    logic [1:0]        done_o;
    logic [1:0]        err_o;
    logic [31:0]       rdata_o;
    logic              busy_o;
    logic [MEM_AW-1:0] mem_addr_o;
    logic              mem_en_o;
    logic [3:0]        mem_we_o;
    logic [31:0]       mem_wdata_o;
    logic [31:0]       mem_rdata_i;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, byteen_i, mem_rdata_i,
        output gnt_o, done_o, err_o, rdata_o, busy_o,
               mem_addr_o, mem_en_o, mem_we_o, mem_wdata_o
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i, byteen_i, mem_rdata_i,
        input  gnt_o, done_o, err_o, rdata_o, busy_o,
               mem_addr_o, mem_en_o, mem_we_o, mem_wdata_o
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins; on a tie the requester
// that did not win last time gets the one-hot grant.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end
endmodule

// File: rtl/dm_arbiter.sv
// CPU/DMA arbiter and sequencer for the single-port data memory. One access
// at a time: grant in IDLE, drive memory in ACCESS, return read data in RESP.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int MEM_AW    = MEM_AW_DEF,
    parameter bit CPU_FIRST = 1'b1
) (
    input logic         clk,
    input logic         reset,
    dm_arbiter_if.slave bus
);
    localparam logic LAST_RST = CPU_FIRST ? REQ_DMA : REQ_CPU;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic              oor_q, oor_d;
    logic [MEM_AW-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;

    logic [1:0]        pick;
    logic              win;
    logic [1:0]        gnt, done, err;
    logic [31:0]       rdata, mem_wdata;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_en;
    logic [3:0]        mem_we;

    rr_arb2 u_rr (
        .req  (bus.req_i),
        .last (last_q),
        .gnt  (pick)
    );

    assign win = pick[1];

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        we_d      = we_q;
        oor_d     = oor_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        gnt       = 2'b00;
        done      = 2'b00;
        err       = 2'b00;
        rdata     = 32'd0;
        mem_en    = 1'b0;
        mem_we    = 4'd0;
        mem_addr  = '0;
        mem_wdata = 32'd0;
        case (state_q)
            IDLE: begin
                if (pick != 2'b00) begin
                    gnt     = pick;
                    owner_d = win;
                    last_d  = win;
                    we_d    = bus.we_i[win];
                    waddr_d = bus.addr_i[win][MEM_AW+1:2];
                    wdata_d = bus.wdata_i[win];
                    be_d    = bus.byteen_i[win];
                    oor_d   = |bus.addr_i[win][31:MEM_AW+2];
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Out-of-range accesses never touch the memory.
                if (oor_q) begin
                    done[owner_q] = 1'b1;
                    err[owner_q]  = 1'b1;
                    state_d       = IDLE;
                end else begin
                    mem_en   = 1'b1;
                    mem_addr = waddr_q;
                    if (we_q) begin
                        mem_we        = be_q;
                        mem_wdata     = wdata_q;
                        done[owner_q] = 1'b1;
                        state_d       = IDLE;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                done[owner_q] = 1'b1;
                rdata         = bus.mem_rdata_i;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= REQ_CPU;
            last_q  <= LAST_RST;
            we_q    <= 1'b0;
            oor_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            oor_q   <= oor_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    assign bus.gnt_o       = gnt;
    assign bus.done_o      = done;
    assign bus.err_o       = err;
    assign bus.rdata_o     = rdata;
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.mem_en_o    = mem_en;
    assign bus.mem_we_o    = mem_we;
    assign bus.mem_addr_o  = mem_addr;
    assign bus.mem_wdata_o = mem_wdata;

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port 4096-word data memory.
- Requester 0 is the CPU M-stage access path; requester 1 is the DMA/debug bus port.
- Serialises accesses with a round-robin policy and drives the memory's word address, byte enables and write data.
- Returns read data and completion/error pulses to the owning requester.

Parameters:
- MEM_AW, 12, memory word-address width (2^MEM_AW words).
- CPU_FIRST, 1, when 1 the round-robin pointer resets so the CPU wins the first contention.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-high reset
- req_i  input  2  per-requester request; [0]=CPU, [1]=DMA
- we_i  input  2  per-requester write flag
- addr_i  input  2x32  per-requester byte address
- wdata_i  input  2x32  per-requester write data, already lane-aligned
- byteen_i  input  2x4  per-requester byte enables
- gnt_o  output  2  one-hot acceptance strobe (combinational)
- done_o  output  2  one-cycle completion pulse
- err_o  output  2  one-cycle out-of-range pulse, coincident with done_o
- rdata_o  output  32  read data, valid while done_o of a read is high
- busy_o  output  1  high whenever state != IDLE (CPU stall source)
- mem_addr_o  output  MEM_AW  memory word index
- mem_en_o  output  1  memory access strobe
- mem_we_o  output  4  per-byte write enables to memory
- mem_wdata_o  output  32  memory write data
- mem_rdata_i  input  32  memory read data, registered, valid the cycle after mem_en_o

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- IDLE, no req: stay in IDLE.
- IDLE, one req: grant it.
- IDLE, both req: grant the requester not granted last (rr pointer).
- On grant:
  - gnt_o[k]=1 this cycle.
  - Latch we/addr/wdata/byteen and owner id k.
  - Update the pointer to k, go to ACCESS.
  - The handshake completes on req&gnt; the requester may drop req the next cycle.
- ACCESS:
  - mem_en_o=1, mem_addr_o=addr[MEM_AW+1:2]; addr[1:0] is ignored (lane selection is encoded in byteen).
  - Write: mem_we_o=byteen, mem_wdata_o=wdata; done_o[k]=1; next state IDLE.
  - Read: mem_we_o=0; next state RESP.
- RESP: rdata_o=mem_rdata_i, done_o[k]=1, next state IDLE.
- Latency from the grant cycle N:
  - Write commits at the edge ending N+1; done at N+1.
  - Read data and done at N+2.
  - gnt_o is 0 outside IDLE, so back-to-back throughput is 1 write per 2 cycles and 1 read per 3 cycles.
- Out of range (addr[31:MEM_AW+2] != 0):
  - ACCESS drives mem_en_o=0 and mem_we_o=0; go directly to IDLE.
  - done_o[k]=1, err_o[k]=1, rdata_o=0.
- Write with byteen=0: no memory write (mem_we_o=0), done still pulses, no err.
- Req dropped before grant: no effect; the pointer does not move.
- Req held after done: treated as a new request in the next IDLE cycle.
- Outside done cycles: rdata_o=0, done_o=0, err_o=0.
- Reset (async, any state):
  - state=IDLE; all outputs 0; latched request cleared.
  - rr pointer = DMA when CPU_FIRST=1, so the CPU wins the first tie.
  - An in-flight access is abandoned: no done, no mem write after reset asserts.

Decomposition:
- Package dm_arb_pkg: state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2), requester ids CPU=0/DMA=1, MEM_AW default.
- One sub-module, rr_arb2: 2-way round-robin picker (req[1:0], last → one-hot grant).

Test Plan:
- CPU write addr=0x0000_0010, byteen=1111, wdata=0xDEADBEEF → gnt[0] cycle N, mem_addr=4 and mem_we=1111 at N+1, done[0] at N+1.
- Then CPU read addr=0x0000_0010 → done[0] at N+2 with rdata=0xDEADBEEF; busy high for 2 cycles.
- Both req continuously (CPU read, DMA write) after reset → grants alternate CPU, DMA, CPU, DMA; no requester starves; each done routes to the correct owner only.
- DMA write addr=0x0001_0000 → done[1] and err[1] together, mem_en stays 0; CPU read of word 0 afterwards returns its prior value.
- CPU sb-style write addr=0x0000_0003, byteen=1000, wdata=0xAB00_0000 → mem_addr=0, mem_we=1000; a later read of word 0 shows only [31:24]=0xAB changed.
- Assert reset during RESP of a read → done/rdata stay 0; state=IDLE after release; first contended grant goes to CPU.
